ram256_arbiter: RTL and testbench

- Two-requester controller for the 256x64 synchronous-read RAM (1-cycle registered read, write on posedge when write=1).
- After reset it zero-fills all 256 entries.
- It then shares the single RAM port between requester 0 (fetch side) and requester 1 (data side) with round-robin arbitration, at most one access per cycle.
- Read data is returned with `rspN_valid` one cycle after the grant.

---
 rtl/ram_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/ram256_arbiter.sv | 107 ++++++++++
 tb/tb_ram256_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared sizing, controller state codes and requester indices for the
// two-port RAM controller.
package ram_ctrl_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: a lone requester always wins; on contention the port
// named by prio wins. Output is one-hot (or zero when idle).
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant[prio] = 1'b1;
        end else begin
            grant = valid;
        end
    end
endmodule

// File: rtl/ram256_arbiter.sv
// Zero-fills a synchronous-read RAM after reset, then shares its single
// port between a fetch requester (0) and a data requester (1), round-robin.
module ram256_arbiter #(
    parameter int ADDR_W         = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W         = ram_ctrl_pkg::DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_out,
    output logic              init_done
);
    import ram_ctrl_pkg::*;

    localparam logic              RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic [1:0]        pend_q, pend_d;
    logic              init_done_q, init_done_d;
    logic [1:0]        req_valid;
    logic [1:0]        grant;

    // Requests are invisible to the arbiter until the fill is finished.
    assign req_valid = (state_q == ST_RUN && reset_n) ? {req1_valid, req0_valid} : 2'b00;

    rr_arbiter2 u_arb (
        .valid (req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        pend_d      = 2'b00;
        init_done_d = init_done_q;
        ram_address = '0;
        ram_in      = '0;
        ram_write   = 1'b0;
        if (state_q == ST_CLEAR) begin
            ram_write   = 1'b1;
            ram_address = cnt_q;
            cnt_d       = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (grant[0]) begin
            ram_address = req0_addr;
            ram_in      = req0_wdata;
            ram_write   = req0_write;
            pend_d[0]   = ~req0_write;
            prio_d      = P1;
        end else if (grant[1]) begin
            ram_address = req1_addr;
            ram_in      = req1_wdata;
            ram_write   = req1_write;
            pend_d[1]   = ~req1_write;
            prio_d      = P0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            prio_q      <= P0;
            pend_q      <= 2'b00;
            init_done_q <= !CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
        end
    end

    // Read data comes straight off the RAM; the pending flag qualifies it.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = pend_q[0];
    assign rsp1_valid = pend_q[1];
    assign rsp_rdata  = ram_out;
    assign init_done  = init_done_q;
endmodule

// File: tb/tb_ram256_arbiter.sv
// Bench for ram256_arbiter: behavioural RAM, fill checks, directed and
// random traffic checked against a shadow-memory reference.
module tb_ram256_arbiter;
    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0]  req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [63:0] rsp_rdata, ram_in, ram_out;
    logic [7:0]  ram_address;
    logic        ram_write, init_done;

    int tests = 0;
    int fails = 0;

    logic [63:0] mem [256];
    logic [63:0] exp_mem [256];
    int          exp_prio;
    logic        exp_pend0, exp_pend1;
    logic [63:0] exp_rdata;

    ram256_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .ram_address(ram_address), .ram_in(ram_in), .ram_write(ram_write),
        .ram_out(ram_out), .init_done(init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_write) mem[ram_address] <= ram_in;
        ram_out <= mem[ram_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_prio  = 0;
        exp_pend0 = 1'b0;
        exp_pend1 = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    endtask

    // Zero-fill: one cleared word per cycle, requests held off meanwhile.
    task automatic clear_check(input int abort_at);
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 8'h03; req0_wdata = 64'h1111;
            req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h04; req1_wdata = 64'h2222;
            #1;
            chk1("clr_write", ram_write, 1'b1);
            chk64("clr_addr", 64'(ram_address), 64'(i));
            chk64("clr_in", ram_in, 64'h0);
            chk1("clr_ready0", req0_ready, 1'b0);
            chk1("clr_ready1", req1_ready, 1'b0);
            chk1("clr_init", init_done, 1'b0);
            chk1("clr_rsp0", rsp0_valid, 1'b0);
            chk1("clr_rsp1", rsp1_valid, 1'b0);
            if (i == abort_at) begin
                #1 reset_n = 1'b0;
                #1;
                chk64("rst_addr", 64'(ram_address), 64'h0);
                chk1("rst_init", init_done, 1'b0);
                chk1("rst_ready0", req0_ready, 1'b0);
                chk1("rst_rsp0", rsp0_valid, 1'b0);
                return;
            end
        end
        model_reset();
    endtask

    task automatic release_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic step(input logic v0, input logic w0, input logic [7:0] a0, input logic [63:0] d0,
                        input logic v1, input logic w1, input logic [7:0] a1, input logic [63:0] d1);
        int g;
        @(negedge clock);
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        g = -1;
        if (v0 && v1) g = exp_prio;
        else if (v0) g = 0;
        else if (v1) g = 1;
        chk1("ready0", req0_ready, g == 0);
        chk1("ready1", req1_ready, g == 1);
        chk1("ram_write", ram_write, (g == 0) ? w0 : (g == 1) ? w1 : 1'b0);
        chk64("ram_addr", 64'(ram_address), 64'((g == 0) ? a0 : (g == 1) ? a1 : 8'h00));
        chk64("ram_in", ram_in, (g == 0) ? d0 : (g == 1) ? d1 : 64'h0);
        chk1("rsp0_valid", rsp0_valid, exp_pend0);
        chk1("rsp1_valid", rsp1_valid, exp_pend1);
        if (exp_pend0 || exp_pend1) chk64("rsp_rdata", rsp_rdata, exp_rdata);
        chk1("init_done", init_done, 1'b1);
        exp_pend0 = 1'b0;
        exp_pend1 = 1'b0;
        if (g == 0) begin
            if (w0) exp_mem[a0] = d0;
            else begin exp_pend0 = 1'b1; exp_rdata = exp_mem[a0]; end
            exp_prio = 1;
        end else if (g == 1) begin
            if (w1) exp_mem[a1] = d1;
            else begin exp_pend1 = 1'b1; exp_rdata = exp_mem[a1]; end
            exp_prio = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
    endtask

    initial begin
        logic       rv0, rw0, rv1, rw1;
        logic [7:0] ra0, ra1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        model_reset();

        release_reset();
        clear_check(100);
        release_reset();
        clear_check(-1);

        step(1'b1, 1'b1, 8'h2A, 64'hDEADBEEF_01234567, 1'b0, 1'b0, 8'h00, 64'h0);
        step(1'b1, 1'b0, 8'h2A, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        idle();

        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 8'h05, 64'h0, 1'b1, 1'b0, 8'h06, 64'h0);
        idle();

        step(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 8'hFF, 64'h55);
        idle();
        step(1'b1, 1'b0, 8'h01, 64'h0, 1'b1, 1'b0, 8'h02, 64'h0);
        step(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 8'hFF, 64'h0);
        idle();

        for (int k = 0; k < 400; k++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            rw0 = 1'($urandom_range(0, 1));
            rw1 = 1'($urandom_range(0, 1));
            ra0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            step(rv0, rw0, ra0, {$urandom, $urandom}, rv1, rw1, ra1, {$urandom, $urandom});
        end
        idle();

        // A read is granted, then reset lands before its response cycle completes.
        step(1'b1, 1'b0, 8'h2A, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk1("rst_drop_rsp0", rsp0_valid, 1'b0);
        chk1("rst_drop_rsp1", rsp1_valid, 1'b0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        clear_check(-1);

        step(1'b1, 1'b0, 8'h2A, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        step(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 8'hFF, 64'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
